// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer and its character ROM.
// MORSE_KEYER_BKSP_EN adds the BKSP state used to key the 16-unit backspace mark.
package morse_pkg;

`ifdef MORSE_KEYER_BKSP_EN
    typedef enum logic [2:0] {IDLE, LOAD, MARK, ELEM_GAP, CHAR_GAP, SPACE, BKSP} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, MARK, ELEM_GAP, CHAR_GAP, SPACE} state_t;
`endif

    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pattern;
    } code_t;

    localparam int BKSP_UNITS     = 16;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int SPACE_UNITS    = 4;
    localparam int DASH_UNITS     = 3;
    localparam int DOT_UNITS      = 1;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int MAX_UNITS      = BKSP_UNITS;

    // Elements are written right-aligned (1 = dash) and stored left-aligned so the next one is always pattern[4].
    function automatic code_t mk_code(input logic [2:0] len, input logic [4:0] bits);
        code_t c;
        c.len     = len;
        c.pattern = bits << (3'd5 - len);
        return c;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational ASCII-to-Morse lookup; lowercase letters fold onto uppercase.
// Backspace (0x08) is only recognised when MORSE_KEYER_BKSP_EN is defined.
module morse_rom
    import morse_pkg::*;
(
    input  logic [7:0] ascii_i,
    output logic       valid_o,
    output logic       is_space_o,
    output logic       is_bksp_o,
    output code_t      code_o
);

    logic [7:0] upper;

    always_comb begin
        upper = ascii_i;
        if (ascii_i >= 8'h61 && ascii_i <= 8'h7A) upper = ascii_i - 8'h20;
    end

    always_comb begin
        valid_o    = 1'b1;
        is_space_o = 1'b0;
        is_bksp_o  = 1'b0;
        code_o     = '0;
        case (upper)
            "A": code_o = mk_code(3'd2, 5'b00001);
            "B": code_o = mk_code(3'd4, 5'b01000);
            "C": code_o = mk_code(3'd4, 5'b01010);
            "D": code_o = mk_code(3'd3, 5'b00100);
            "E": code_o = mk_code(3'd1, 5'b00000);
            "F": code_o = mk_code(3'd4, 5'b00010);
            "G": code_o = mk_code(3'd3, 5'b00110);
            "H": code_o = mk_code(3'd4, 5'b00000);
            "I": code_o = mk_code(3'd2, 5'b00000);
            "J": code_o = mk_code(3'd4, 5'b00111);
            "K": code_o = mk_code(3'd3, 5'b00101);
            "L": code_o = mk_code(3'd4, 5'b00100);
            "M": code_o = mk_code(3'd2, 5'b00011);
            "N": code_o = mk_code(3'd2, 5'b00010);
            "O": code_o = mk_code(3'd3, 5'b00111);
            "P": code_o = mk_code(3'd4, 5'b00110);
            "Q": code_o = mk_code(3'd4, 5'b01101);
            "R": code_o = mk_code(3'd3, 5'b00010);
            "S": code_o = mk_code(3'd3, 5'b00000);
            "T": code_o = mk_code(3'd1, 5'b00001);
            "U": code_o = mk_code(3'd3, 5'b00001);
            "V": code_o = mk_code(3'd4, 5'b00001);
            "W": code_o = mk_code(3'd3, 5'b00011);
            "X": code_o = mk_code(3'd4, 5'b01001);
            "Y": code_o = mk_code(3'd4, 5'b01011);
            "Z": code_o = mk_code(3'd4, 5'b01100);
            "0": code_o = mk_code(3'd5, 5'b11111);
            "1": code_o = mk_code(3'd5, 5'b01111);
            "2": code_o = mk_code(3'd5, 5'b00111);
            "3": code_o = mk_code(3'd5, 5'b00011);
            "4": code_o = mk_code(3'd5, 5'b00001);
            "5": code_o = mk_code(3'd5, 5'b00000);
            "6": code_o = mk_code(3'd5, 5'b10000);
            "7": code_o = mk_code(3'd5, 5'b11000);
            "8": code_o = mk_code(3'd5, 5'b11100);
            "9": code_o = mk_code(3'd5, 5'b11110);
            8'h20: is_space_o = 1'b1;
`ifdef MORSE_KEYER_BKSP_EN
            8'h08: is_bksp_o = 1'b1;
`endif
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts one ASCII character per handshake and keys sw_out (active-low).
// Defining MORSE_KEYER_BKSP_EN adds the 16-unit backspace mark for 0x08.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_BASE = 1350000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] speed,
    output logic       sw_out,
    output logic       busy,
    output logic       bad_char
);

    localparam int CNT_W = $clog2(MAX_UNITS * 8 * UNIT_BASE + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] unit_len_q, unit_len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit;
    logic [7:0]       char_q, char_d;
    logic [4:0]       pat_q, pat_d;
    logic [2:0]       left_q, left_d;
    logic             sw_q, sw_d;
    logic [4:0]       units;
    logic             last;
    logic             rom_valid, rom_is_space, rom_is_bksp;
    code_t            rom_code;

    morse_rom u_rom (
        .ascii_i    (char_q),
        .valid_o    (rom_valid),
        .is_space_o (rom_is_space),
        .is_bksp_o  (rom_is_bksp),
        .code_o     (rom_code)
    );

    // Each timed state lasts a whole number of units; the counter spans the full state.
    always_comb begin
        units = 5'(ELEM_GAP_UNITS);
        case (state_q)
            MARK:     units = pat_q[4] ? 5'(DASH_UNITS) : 5'(DOT_UNITS);
            CHAR_GAP: units = 5'(CHAR_GAP_UNITS);
            SPACE:    units = 5'(SPACE_UNITS);
`ifdef MORSE_KEYER_BKSP_EN
            BKSP:     units = 5'(BKSP_UNITS);
`endif
            default:  units = 5'(ELEM_GAP_UNITS);
        endcase
    end

    assign limit = unit_len_q * CNT_W'(units);
    assign last  = (cnt_q == limit - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        unit_len_d = unit_len_q;
        char_d     = char_q;
        pat_d      = pat_q;
        left_d     = left_q;
        bad_char   = 1'b0;
        cnt_d      = last ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (in_valid) begin
                    state_d    = LOAD;
                    char_d     = ascii_in;
                    unit_len_d = CNT_W'(UNIT_BASE) * CNT_W'(4'd8 - {1'b0, speed});
                end
            end
            LOAD: begin
                cnt_d = '0;
`ifdef MORSE_KEYER_BKSP_EN
                if (!rom_valid) begin
                    bad_char = 1'b1;
                    state_d  = IDLE;
                end else if (rom_is_space) begin
                    state_d = SPACE;
                end else if (rom_is_bksp) begin
                    state_d = BKSP;
                end else begin
`else
                if (!rom_valid || rom_is_bksp) begin
                    bad_char = 1'b1;
                    state_d  = IDLE;
                end else if (rom_is_space) begin
                    state_d = SPACE;
                end else begin
`endif
                    state_d = MARK;
                    pat_d   = rom_code.pattern;
                    left_d  = rom_code.len;
                end
            end
            MARK: begin
                if (last) begin
                    if (left_q > 3'd1) begin
                        state_d = ELEM_GAP;
                        left_d  = left_q - 3'd1;
                        pat_d   = pat_q << 1;
                    end else begin
                        state_d = CHAR_GAP;
                    end
                end
            end
            ELEM_GAP: if (last) state_d = MARK;
            CHAR_GAP: if (last) state_d = IDLE;
            SPACE:    if (last) state_d = IDLE;
`ifdef MORSE_KEYER_BKSP_EN
            BKSP:     if (last) state_d = CHAR_GAP;
`endif
            default:  state_d = IDLE;
        endcase
        // Key down is decoded from the next state so sw_out changes on the same edge as the state.
        sw_d = (state_d != MARK);
`ifdef MORSE_KEYER_BKSP_EN
        if (state_d == BKSP) sw_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            unit_len_q <= '0;
            cnt_q      <= '0;
            char_q     <= '0;
            pat_q      <= '0;
            left_q     <= '0;
            sw_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            unit_len_q <= unit_len_d;
            cnt_q      <= cnt_d;
            char_q     <= char_d;
            pat_q      <= pat_d;
            left_q     <= left_d;
            sw_q       <= sw_d;
        end
    end

    assign sw_out   = sw_q;
    assign busy     = (state_q != IDLE);
    assign in_ready = (state_q == IDLE);

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer with UNIT_BASE=4: table vectors, corner sequences and random characters.
// The reference model expands dot/dash strings into expected per-cycle outputs.
module tb_morse_keyer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ascii_in;
    logic       in_valid;
    logic [2:0] speed;
    logic       in_ready;
    logic       sw_out;
    logic       busy;
    logic       bad_char;

    int checks = 0;
    int errors = 0;
    int lowCnt, busyCnt, badCnt, lowAfter;
    logic [3:0] expQ[$];

    typedef struct {
        logic [7:0] ch;
        logic [2:0] spd;
        int         expLow;
        int         expBusy;
        int         expBad;
    } vec_t;

    vec_t vecs[12];

    morse_keyer #(.UNIT_BASE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .ascii_in (ascii_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .speed    (speed),
        .sw_out   (sw_out),
        .busy     (busy),
        .bad_char (bad_char)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic string morseOf(input logic [7:0] c);
        logic [7:0] up;
        up = c;
        if (c >= 8'h61 && c <= 8'h7A) up = c - 8'h20;
        case (up)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
            "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
            "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
            "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
            "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
            "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
            "8": return "---.."; "9": return "----.";
            8'h20: return "SP";
`ifdef MORSE_KEYER_BKSP_EN
            8'h08: return "BS";
`endif
            default: return "";
        endcase
    endfunction

    // Expected {sw_out, busy, bad_char, in_ready} for every cycle after the handshake edge.
    function automatic void buildExpected(input logic [7:0] c, input logic [2:0] spd);
        int u;
        string m;
        u = 4 * (8 - int'(spd));
        m = morseOf(c);
        expQ.delete();
        if (m.len() == 0) begin
            expQ.push_back(4'b1110);
        end else begin
            expQ.push_back(4'b1100);
            if (m == "SP") begin
                repeat (4 * u) expQ.push_back(4'b1100);
            end else if (m == "BS") begin
                repeat (16 * u) expQ.push_back(4'b0100);
                repeat (3 * u) expQ.push_back(4'b1100);
            end else begin
                for (int k = 0; k < m.len(); k++) begin
                    if (k > 0) repeat (u) expQ.push_back(4'b1100);
                    repeat ((m[k] == "-") ? 3 * u : u) expQ.push_back(4'b0100);
                end
                repeat (3 * u) expQ.push_back(4'b1100);
            end
        end
        expQ.push_back(4'b1001);
    endfunction

    task automatic applyStimulus(input logic [7:0] c, input logic [2:0] spd, input bit hold,
                                 input int changeAt, input logic [2:0] newSpd);
        int n = 0;
        logic [3:0] got;
        buildExpected(c, spd);
        lowCnt  = 0;
        busyCnt = 0;
        badCnt  = 0;
        ascii_in = c;
        in_valid = 1'b1;
        speed    = spd;
        while (!in_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("ready_before_%02h", c), in_ready, 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int i = 0; i < expQ.size(); i++) begin
            @(negedge clk);
            if (i == 0 && !hold) in_valid = 1'b0;
            if (i == changeAt) speed = newSpd;
            got = {sw_out, busy, bad_char, in_ready};
            checkOutput($sformatf("wave_%02h_cyc%0d", c, i + 1), got, expQ[i]);
            if (!sw_out) lowCnt++;
            if (busy) busyCnt++;
            if (bad_char) badCnt++;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sel;
        logic [7:0] c;
        logic [2:0] s;

        vecs[0]  = '{8'h45, 3'd7, 4, 17, 0};
        vecs[1]  = '{8'h61, 3'd7, 16, 33, 0};
        vecs[2]  = '{8'h41, 3'd7, 16, 33, 0};
        vecs[3]  = '{8'h23, 3'd7, 0, 1, 1};
        vecs[4]  = '{8'h54, 3'd7, 12, 25, 0};
        vecs[5]  = '{8'h20, 3'd7, 0, 17, 0};
        vecs[6]  = '{8'h35, 3'd7, 20, 49, 0};
        vecs[7]  = '{8'h30, 3'd6, 120, 177, 0};
        vecs[8]  = '{8'h53, 3'd5, 36, 97, 0};
        vecs[9]  = '{8'h7A, 3'd7, 32, 57, 0};
        vecs[10] = '{8'h39, 3'd7, 52, 81, 0};
`ifdef MORSE_KEYER_BKSP_EN
        vecs[11] = '{8'h08, 3'd7, 64, 77, 0};
`else
        vecs[11] = '{8'h08, 3'd7, 0, 1, 1};
`endif

        reset    = 1'b1;
        ascii_in = 8'h00;
        in_valid = 1'b0;
        speed    = 3'd7;
        #1;
        checkOutput("reset_state", {sw_out, busy, bad_char, in_ready}, 4'b1001);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].ch, vecs[v].spd, 1'b0, -1, 3'd0);
            checkOutput($sformatf("low_%02h", vecs[v].ch), lowCnt, vecs[v].expLow);
            checkOutput($sformatf("busy_%02h", vecs[v].ch), busyCnt, vecs[v].expBusy);
            checkOutput($sformatf("bad_%02h", vecs[v].ch), badCnt, vecs[v].expBad);
        end

        // "T T" with in_valid held high across all three characters
        applyStimulus(8'h54, 3'd7, 1'b1, -1, 3'd0);
        checkOutput("tt_first_low", lowCnt, 12);
        applyStimulus(8'h20, 3'd7, 1'b1, -1, 3'd0);
        checkOutput("tt_space_busy", busyCnt, 17);
        applyStimulus(8'h54, 3'd7, 1'b0, -1, 3'd0);
        checkOutput("tt_second_low", lowCnt, 12);

        // '0' at the slowest speed with speed raised mid-character
        applyStimulus(8'h30, 3'd0, 1'b0, 50, 3'd7);
        checkOutput("slow0_low", lowCnt, 480);
        checkOutput("slow0_busy", busyCnt, 705);

        // Reset during the second dot of '5'
        ascii_in = 8'h35;
        in_valid = 1'b1;
        speed    = 3'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("pre_reset_mark", {sw_out, busy}, 2'b01);
        #2 reset = 1'b1;
        #1 checkOutput("reset_async", {sw_out, busy, bad_char, in_ready}, 4'b1001);
        @(negedge clk);
        reset = 1'b0;
        lowAfter = 0;
        repeat (40) begin
            @(negedge clk);
            if (!sw_out) lowAfter++;
        end
        checkOutput("no_resume_low", lowAfter, 0);
        checkOutput("no_resume_idle", {busy, in_ready}, 2'b01);

        applyStimulus(8'h08, 3'd7, 1'b0, -1, 3'd0);
`ifdef MORSE_KEYER_BKSP_EN
        checkOutput("bksp_low", lowCnt, 64);
`else
        checkOutput("bksp_bad", badCnt, 1);
`endif

        for (int r = 0; r < 25; r++) begin
            sel = $urandom_range(0, 9);
            s   = 3'($urandom_range(0, 7));
            if (sel < 3)       c = 8'h41 + 8'($urandom_range(0, 25));
            else if (sel < 6)  c = 8'h61 + 8'($urandom_range(0, 25));
            else if (sel < 8)  c = 8'h30 + 8'($urandom_range(0, 9));
            else if (sel == 8) c = 8'h20;
            else               c = 8'($urandom_range(0, 255));
            applyStimulus(c, s, 1'b0, -1, 3'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
